// File: rtl/jk_multimode_reg.sv
// Multimode WIDTH-bit register: per-bit JK flip-flops, up/down toggle-chain counter or left shifter.
// tc is a combinational terminal-count flag; wrap is a registered one-cycle counter rollover pulse.
module jk_multimode_reg #(
    parameter int unsigned     WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             sin,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_JK    = 2'b00,
        MODE_UP    = 2'b01,
        MODE_DOWN  = 2'b10,
        MODE_SHIFT = 2'b11
    } mode_e;

    mode_e            mode_s;
    logic [WIDTH-1:0] up_tog;
    logic [WIDTH-1:0] dn_tog;
    logic [WIDTH-1:0] jk_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             all_ones;
    logic             all_zeros;
    logic             wrap_nxt;

    assign mode_s    = mode_e'(mode);
    assign all_ones  = &Q;
    assign all_zeros = ~|Q;

    // Toggle chains: bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        up_tog    = '0;
        dn_tog    = '0;
        up_tog[0] = 1'b1;
        dn_tog[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            up_tog[i] = up_tog[i-1] & Q[i-1];
            dn_tog[i] = dn_tog[i-1] & ~Q[i-1];
        end
    end

    // Independent per-bit JK update.
    always_comb begin
        jk_nxt = Q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            case ({J[i], K[i]})
                2'b01:   jk_nxt[i] = 1'b0;
                2'b10:   jk_nxt[i] = 1'b1;
                2'b11:   jk_nxt[i] = ~Q[i];
                default: jk_nxt[i] = Q[i];
            endcase
        end
    end

    always_comb begin
        q_nxt    = Q;
        wrap_nxt = 1'b0;
        case (mode_s)
            MODE_JK:    q_nxt = jk_nxt;
            MODE_UP: begin
                q_nxt    = Q ^ up_tog;
                wrap_nxt = all_ones;
            end
            MODE_DOWN: begin
                q_nxt    = Q ^ dn_tog;
                wrap_nxt = all_zeros;
            end
            MODE_SHIFT: q_nxt = {Q[WIDTH-2:0], sin};
            default:    q_nxt = Q;
        endcase
    end

    assign tc = ((mode_s == MODE_UP) && all_ones) || ((mode_s == MODE_DOWN) && all_zeros);

    // Reset aborts any pending wrap; a disabled edge holds Q and clears wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            Q    <= RST_VAL;
            wrap <= 1'b0;
        end else if (en) begin
            Q    <= q_nxt;
            wrap <= wrap_nxt;
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: doc/jk_multimode_reg.md
JK_MULTIMODE_REG -- requirements
Module: jk_multimode_reg

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, register width in bits; legal range 2..32.
REQ-002 SHALL provide parameter RST_VAL, default 0, WIDTH-bit value loaded into Q on reset.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port en  input  1  update enable; Q holds when low.
REQ-006 SHALL provide port mode  input  2  operating mode: 00 JK, 01 count up, 10 count down, 11 shift left.
REQ-007 SHALL provide port J  input  WIDTH  per-bit J inputs, used in mode 00 only.
REQ-008 SHALL provide port K  input  WIDTH  per-bit K inputs, used in mode 00 only.
REQ-009 SHALL provide port sin  input  1  serial input, used in mode 11 only.
REQ-010 SHALL provide port Q  output  WIDTH  registered state.
REQ-011 SHALL provide port tc  output  1  combinational terminal-count flag.
REQ-012 SHALL provide port wrap  output  1  registered one-cycle counter wrap pulse.

Function
REQ-013 Mode 00 SHALL update each bit i independently per {J[i],K[i]}: 00 hold, 01 clear to 0, 10 set to 1, 11 toggle.
REQ-014 Mode 01 SHALL behave as a synchronous toggle-chain up counter: bit i toggles iff all bits below i are 1 (Q+1 modulo 2^WIDTH).
REQ-015 Mode 10 SHALL behave as a synchronous down counter: bit i toggles iff all bits below i are 0 (Q-1 modulo 2^WIDTH).
REQ-016 Mode 11 SHALL shift left one position per enabled edge: Q becomes {Q[WIDTH-2:0], sin}; Q[WIDTH-1] is discarded.
REQ-017 J, K and sin SHALL have no effect outside their own modes.
REQ-018 tc SHALL be 1 iff (mode=01 and Q all ones) or (mode=10 and Q all zeros); else 0, including modes 00 and 11.
REQ-019 wrap SHALL be 1 in the cycle after an enabled edge where Q passed all-ones to all-zeros in mode 01, or all-zeros to all-ones in mode 10; otherwise 0.
REQ-020 wrap SHALL never assert in modes 00 or 11, even if Q goes from all-ones to all-zeros there.
REQ-021 With en=0 and rst=0, Q SHALL hold, and wrap SHALL be 0 after that edge.
REQ-022 A mode change SHALL take effect on the same edge it is sampled; there is no pipeline and latency from inputs to Q is one clock.
REQ-023 tc SHALL follow mode and Q combinationally with zero latency.
REQ-024 The block SHALL contain no latches and no combinational path from J, K, sin or en to any output.

Reset
REQ-025 On a rising clk edge with rst=1, Q SHALL load RST_VAL and wrap SHALL load 0, regardless of en, mode, J, K or sin.
REQ-026 rst SHALL take priority over en and every mode.
REQ-027 rst asserted mid-count SHALL abort the count with no wrap pulse, even if the same edge would have wrapped.
REQ-028 Outputs before the first reset edge are undefined; the bench SHALL NOT check them.

Verification (WIDTH=4, RST_VAL=0)
REQ-029 Reset: rst=1, en=1, mode=11, sin=1, one edge -> Q=0000, wrap=0; rst at Q=1111 in mode 01 -> Q=0000, wrap=0.
REQ-030 JK mode, toggle behaviour:
- Start Q=0000; apply J=1010, K=0110 -> Q=1010.
- Same inputs again -> Q=1000 (bit1 toggles, bit3 stays set).
- J=K=0000 -> Q holds 1000.
REQ-031 Up count: load 1110, mode=01, en=1:
- Q=1110, tc=0 -> next edge Q=1111, tc=1.
- Next edge -> Q=0000, wrap=1.
- Next edge -> Q=0001, wrap=0.
REQ-032 Down count and mode gating:
- Mode 10 from Q=0001 -> Q=0000, tc=1; next edge -> Q=1111, wrap=1.
- Switching to mode 00 at Q=0000 -> tc=0.
REQ-033 Shift and non-count wrap: mode 11, Q=1001, sin=1 -> Q=0011; then sin=0 -> Q=0110.
- JK mode from Q=1111 with K=1111, J=0000 -> Q=0000, wrap=0.
REQ-034 Enable: mode 01 at Q=0101, en=0 for 3 edges -> Q stays 0101, wrap=0; en=1 -> Q=0110.
